// File: rtl/libAritimeticalControl.sv
// ALU control codes; FUNC tells ALU control to decode the R-type funct field.
package libAritimeticalControl;
   localparam logic [3:0] ARCTRL_ZERO = 4'd0;
   localparam logic [3:0] ARCTRL_ADD  = 4'd1;
   localparam logic [3:0] ARCTRL_SUB  = 4'd2;
   localparam logic [3:0] ARCTRL_AND  = 4'd3;
   localparam logic [3:0] ARCTRL_OR   = 4'd4;
   localparam logic [3:0] ARCTRL_XOR  = 4'd5;
   localparam logic [3:0] ARCTRL_SLT  = 4'd6;
   localparam logic [3:0] ARCTRL_LU   = 4'd7;
   localparam logic [3:0] ARCTRL_FUNC = 4'd8;
endpackage

// File: rtl/libControl.sv
// Multicycle controller definitions: FSM states, trap causes and datapath mux encodings.
package libControl;
   import libInstructions::*;
   import libAritimeticalControl::*;

   typedef enum logic [3:0] {
      FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR,
      MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, TRAP
   } ctrlState_t;

   localparam logic [1:0] TRAP_NONE    = 2'd0;
   localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
   localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

   localparam logic [1:0] SRCB_RT     = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMMSH2 = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   localparam logic [1:0] BR_EQ = 2'd1;
   localparam logic [1:0] BR_NE = 2'd2;

   function automatic logic [3:0] immAluOp(input logic [5:0] op);
      case (op)
         OP_ANDI: immAluOp = ARCTRL_AND;
         OP_ORI:  immAluOp = ARCTRL_OR;
         OP_XORI: immAluOp = ARCTRL_XOR;
         OP_SLTI: immAluOp = ARCTRL_SLT;
         OP_LUI:  immAluOp = ARCTRL_LU;
         default: immAluOp = ARCTRL_ADD;
      endcase
   endfunction
endpackage

// File: rtl/libInstructions.sv
// MIPS primary opcode values (instruction bits [31:26]) decoded by the control unit.
package libInstructions;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory state; flags expiry when the
// limit is already reached and memory is still not ready.
module mem_wait_timer #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic memReady,
   output logic expired
);
   logic [TIMER_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset || !active || memReady)
         r_count <= '0;
      else if (r_count != '1)
         r_count <= r_count + TIMER_W'(1);
   end

   assign expired = (TIMEOUT_CYCLES != 0) && active && !memReady &&
                    (r_count == TIMER_W'(TIMEOUT_CYCLES));
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/
// write-back with a memory-ready handshake, wait timeout and sticky trap.
module multicycle_controller
   import libInstructions::*, libAritimeticalControl::*, libControl::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       memReady,
   output logic       pcWrite,
   output logic [1:0] branch,
   output logic [1:0] pcSource,
   output logic       iorD,
   output logic       irWrite,
   output logic       memRead,
   output logic       memWrite,
   output logic       memToReg,
   output logic       regDst,
   output logic       regWrite,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [3:0] aluOp,
   output logic       instrDone,
   output logic       trap,
   output logic [1:0] trapCause
);
   ctrlState_t r_state, w_nextState;
   logic       r_trap;
   logic [1:0] r_trapCause, w_trapCause;
   logic       w_timerActive, w_expired;

   assign w_timerActive = (r_state == FETCH) || (r_state == MEM_RD) || (r_state == MEM_WR);

   mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TIMER_W(TIMER_W)) u_timer (
      .clk(clk), .reset(reset), .active(w_timerActive),
      .memReady(memReady), .expired(w_expired)
   );

   // Trap registers only load on the edge that enters TRAP, so they stay frozen there.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= FETCH;
         r_trap      <= 1'b0;
         r_trapCause <= TRAP_NONE;
      end else begin
         r_state <= w_nextState;
         if (w_nextState == TRAP && r_state != TRAP) begin
            r_trap      <= 1'b1;
            r_trapCause <= w_trapCause;
         end
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_trapCause = TRAP_NONE;
      case (r_state)
         FETCH:
            if (memReady) w_nextState = DECODE;
            else if (w_expired) begin
               w_nextState = TRAP;
               w_trapCause = TRAP_TIMEOUT;
            end
         DECODE:
            case (opcode)
               OP_RTYPE:                                        w_nextState = EXEC_R;
               OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI: w_nextState = EXEC_I;
               OP_LW, OP_SW:                                    w_nextState = MEM_ADDR;
               OP_BEQ, OP_BNE:                                  w_nextState = BRANCH;
               OP_J:                                            w_nextState = JUMP;
               default: begin
                  w_nextState = TRAP;
                  w_trapCause = TRAP_ILLEGAL;
               end
            endcase
         EXEC_R, EXEC_I: w_nextState = ALU_WB;
         ALU_WB, MEM_WB, BRANCH, JUMP: w_nextState = FETCH;
         MEM_ADDR: w_nextState = (opcode == OP_LW) ? MEM_RD : MEM_WR;
         MEM_RD, MEM_WR:
            if (memReady) w_nextState = (r_state == MEM_RD) ? MEM_WB : FETCH;
            else if (w_expired) begin
               w_nextState = TRAP;
               w_trapCause = TRAP_TIMEOUT;
            end
         TRAP:    w_nextState = TRAP;
         default: w_nextState = FETCH;
      endcase
   end

   // Outputs are forced low during reset so nothing strobes in the reset cycle.
   always_comb begin
      pcWrite   = 1'b0;
      branch    = 2'd0;
      pcSource  = PCSRC_ALU;
      iorD      = 1'b0;
      irWrite   = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      memToReg  = 1'b0;
      regDst    = 1'b0;
      regWrite  = 1'b0;
      aluSrcA   = 1'b0;
      aluSrcB   = SRCB_RT;
      aluOp     = ARCTRL_ZERO;
      instrDone = 1'b0;
      trap      = 1'b0;
      trapCause = TRAP_NONE;
      if (!reset) begin
         trap      = r_trap;
         trapCause = r_trapCause;
         case (r_state)
            FETCH: begin
               memRead = 1'b1;
               aluSrcB = SRCB_FOUR;
               aluOp   = ARCTRL_ADD;
               irWrite = memReady;
               pcWrite = memReady;
            end
            DECODE: begin
               aluSrcB = SRCB_IMMSH2;
               aluOp   = ARCTRL_ADD;
            end
            EXEC_R: begin
               aluSrcA = 1'b1;
               aluOp   = ARCTRL_FUNC;
            end
            EXEC_I: begin
               aluSrcA = 1'b1;
               aluSrcB = SRCB_IMM;
               aluOp   = immAluOp(opcode);
            end
            ALU_WB: begin
               regWrite  = 1'b1;
               regDst    = (opcode == OP_RTYPE);
               instrDone = 1'b1;
            end
            MEM_ADDR: begin
               aluSrcA = 1'b1;
               aluSrcB = SRCB_IMM;
               aluOp   = ARCTRL_ADD;
            end
            MEM_RD: begin
               memRead = 1'b1;
               iorD    = 1'b1;
            end
            MEM_WB: begin
               regWrite  = 1'b1;
               memToReg  = 1'b1;
               instrDone = 1'b1;
            end
            MEM_WR: begin
               memWrite  = 1'b1;
               iorD      = 1'b1;
               instrDone = memReady;
            end
            BRANCH: begin
               aluSrcA   = 1'b1;
               aluOp     = ARCTRL_SUB;
               pcSource  = PCSRC_ALUOUT;
               branch    = (opcode == OP_BNE) ? BR_NE : BR_EQ;
               instrDone = 1'b1;
            end
            JUMP: begin
               pcWrite   = 1'b1;
               pcSource  = PCSRC_JUMP;
               instrDone = 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised instruction streams checked cycle by cycle against a per-instruction
// schedule model built from opcode class and memory wait counts.
module tb_multicycle_controller;
   import libAritimeticalControl::*;

   localparam int T = 4;

   typedef struct packed {
      logic       pcWrite;
      logic [1:0] branch;
      logic [1:0] pcSource;
      logic       iorD, irWrite, memRead, memWrite, memToReg, regDst, regWrite, aluSrcA;
      logic [1:0] aluSrcB;
      logic [3:0] aluOp;
      logic       instrDone, trap;
      logic [1:0] trapCause;
   } outv_t;

   logic       clk, reset, memReady;
   logic [5:0] opcode;
   logic       pcWrite, iorD, irWrite, memRead, memWrite, memToReg, regDst, regWrite;
   logic       aluSrcA, instrDone, trap;
   logic [1:0] branch, pcSource, aluSrcB, trapCause;
   logic [3:0] aluOp;
   outv_t      obs;

   int errs = 0, checks = 0, n_done = 0, n_retired = 0;
   bit         m_trapped = 0;
   logic [1:0] m_cause = 2'd0;
   logic [5:0] ops [12] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A,
                            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

   multicycle_controller #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
      .pcWrite(pcWrite), .branch(branch), .pcSource(pcSource), .iorD(iorD),
      .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
      .regDst(regDst), .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
      .aluOp(aluOp), .instrDone(instrDone), .trap(trap), .trapCause(trapCause)
   );

   assign obs = {pcWrite, branch, pcSource, iorD, irWrite, memRead, memWrite, memToReg,
                 regDst, regWrite, aluSrcA, aluSrcB, aluOp, instrDone, trap, trapCause};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (instrDone) n_done <= n_done + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic rdy, input outv_t e);
      @(negedge clk);
      memReady = rdy;
      #1;
      chk(tag, 32'(obs), 32'(e));
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset    = 1'b1;
         memReady = 1'($urandom);
         opcode   = 6'($urandom);
         #1;
         chk("reset", 32'(obs), 32'd0);
      end
      @(posedge clk);
      #1;
      reset     = 1'b0;
      memReady  = 1'b0;
      m_trapped = 0;
      m_cause   = 2'd0;
   endtask

   task automatic trap_cycles(input int n);
      outv_t e;
      e = '0;
      e.trap = 1'b1;
      e.trapCause = m_cause;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         opcode   = 6'($urandom);
         memReady = 1'($urandom);
         #1;
         chk("trap", 32'(obs), 32'(e));
      end
   endtask

   // More than T consecutive not-ready cycles in one memory state traps.
   task automatic mem_phase(input string tag, input outv_t base, input outv_t done,
                            input int w, output bit tr);
      int n;
      n = (w > T) ? T + 1 : w;
      for (int i = 0; i < n; i++) cyc(tag, 1'b0, base);
      tr = (w > T);
      if (tr) begin
         m_trapped = 1;
         m_cause   = 2'd2;
      end else cyc(tag, 1'b1, done);
   endtask

   function automatic logic [3:0] imm_op(input logic [5:0] op);
      case (op)
         6'h0A:   return ARCTRL_SLT;
         6'h0C:   return ARCTRL_AND;
         6'h0D:   return ARCTRL_OR;
         6'h0E:   return ARCTRL_XOR;
         6'h0F:   return ARCTRL_LU;
         default: return ARCTRL_ADD;
      endcase
   endfunction

   task automatic do_instr(input logic [5:0] op, input int fw, input int mw);
      outv_t f, fd, e, d;
      bit tr;
      opcode = op;
      f = '0; f.memRead = 1; f.aluSrcB = 2'd1; f.aluOp = ARCTRL_ADD;
      fd = f; fd.irWrite = 1; fd.pcWrite = 1;
      mem_phase("fetch", f, fd, fw, tr);
      if (tr) return;
      e = '0; e.aluSrcB = 2'd3; e.aluOp = ARCTRL_ADD;
      cyc("decode", 1'($urandom), e);
      case (op)
         6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
            e = '0; e.aluSrcA = 1;
            if (op == 6'h00) e.aluOp = ARCTRL_FUNC;
            else begin e.aluSrcB = 2'd2; e.aluOp = imm_op(op); end
            cyc("exec", 1'($urandom), e);
            e = '0; e.regWrite = 1; e.regDst = (op == 6'h00); e.instrDone = 1;
            cyc("alu_wb", 1'($urandom), e);
            n_retired++;
         end
         6'h23, 6'h2B: begin
            e = '0; e.aluSrcA = 1; e.aluSrcB = 2'd2; e.aluOp = ARCTRL_ADD;
            cyc("mem_addr", 1'($urandom), e);
            e = '0; e.iorD = 1;
            if (op == 6'h23) e.memRead = 1; else e.memWrite = 1;
            d = e;
            if (op == 6'h2B) d.instrDone = 1;
            mem_phase(op == 6'h23 ? "mem_rd" : "mem_wr", e, d, mw, tr);
            if (tr) return;
            if (op == 6'h23) begin
               e = '0; e.regWrite = 1; e.memToReg = 1; e.instrDone = 1;
               cyc("mem_wb", 1'($urandom), e);
            end
            n_retired++;
         end
         6'h04, 6'h05: begin
            e = '0; e.aluSrcA = 1; e.aluOp = ARCTRL_SUB; e.pcSource = 2'd1;
            e.branch = (op == 6'h05) ? 2'd2 : 2'd1; e.instrDone = 1;
            cyc("branch", 1'($urandom), e);
            n_retired++;
         end
         6'h02: begin
            e = '0; e.pcWrite = 1; e.pcSource = 2'd2; e.aluOp = ARCTRL_ZERO; e.instrDone = 1;
            cyc("jump", 1'($urandom), e);
            n_retired++;
         end
         default: begin
            m_trapped = 1;
            m_cause   = 2'd1;
         end
      endcase
   endtask

   function automatic int pick_wait();
      int r;
      r = $urandom_range(0, 99);
      if (r < 50) return 0;
      if (r < 85) return $urandom_range(1, 3);
      if (r < 95) return T;
      return T + 1;
   endfunction

   initial begin
      outv_t e;
      reset = 1'b1; memReady = 1'b0; opcode = 6'h00;
      do_reset(3);

      do_instr(6'h00, 0, 0);                 // R-type ADD
      do_instr(6'h23, 0, 3);                 // LW with three wait states
      do_instr(6'h05, 0, 0);                 // BNE
      do_instr(6'h3F, 0, 0);                 // illegal opcode
      chk("illegal_trapped", 32'(m_trapped), 32'd1);
      trap_cycles(20);
      do_reset(1);
      do_instr(6'h08, T + 1, 0);             // fetch timeout
      trap_cycles(5);
      do_reset(1);
      do_instr(6'h08, T, 0);                 // ready exactly at the limit wins
      do_instr(6'h2B, 0, T + 1);             // store timeout
      trap_cycles(3);
      do_reset(1);

      // Reset in the middle of a store wait
      opcode = 6'h2B;
      e = '0; e.memRead = 1; e.aluSrcB = 2'd1; e.aluOp = ARCTRL_ADD; e.irWrite = 1; e.pcWrite = 1;
      cyc("sw_fetch", 1'b1, e);
      e = '0; e.aluSrcB = 2'd3; e.aluOp = ARCTRL_ADD;
      cyc("sw_decode", 1'b0, e);
      e = '0; e.aluSrcA = 1; e.aluSrcB = 2'd2; e.aluOp = ARCTRL_ADD;
      cyc("sw_addr", 1'b0, e);
      e = '0; e.memWrite = 1; e.iorD = 1;
      cyc("sw_wait", 1'b0, e);
      cyc("sw_wait", 1'b0, e);
      do_reset(1);
      do_instr(6'h00, 1, 0);

      for (int k = 0; k < 150; k++) begin
         logic [5:0] op;
         op = ($urandom_range(0, 99) < 5) ? 6'($urandom) : ops[$urandom_range(0, 11)];
         do_instr(op, pick_wait(), pick_wait());
         if (m_trapped) begin
            trap_cycles(3);
            do_reset(1);
         end
      end

      @(negedge clk);
      chk("retired", n_done, n_retired);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
